pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage MIPS pipeline; generalises the combinational Control_Unit flush logic.
// - Detects load-use hazards and inserts a configurable number of bubbles.
// - Flushes wrong-path stages for branches resolved in EX or MEM, and for ID-stage jumps.
// - Freezes the whole pipeline while data memory is not ready, and enters a sticky halt state.
// PARAMETERS
// - REG_AW           5   register address width
// - BRANCH_STAGE     2   stage resolving branches: 2=EX (flush IF/ID, ID/EX), 3=MEM (also flush EX/MEM)
// - LOAD_USE_BUBBLES 1   bubbles per load-use hazard: 1..3 (1 with MEM->EX forwarding)
// - MEM_WAIT_MAX     15  wait cycles before MemTimeout; counter width $clog2(MEM_WAIT_MAX+1)
// PORTS
// - CLK          in   1       clock, rising edge
// - Reset        in   1       synchronous, active-high
// - ID_Rs        in   REG_AW  rs of instruction in ID
// - ID_Rt        in   REG_AW  rt of instruction in ID
// - ID_UsesRt    in   1       ID instruction reads rt
// - EX_MemRead   in   1       instruction in EX is a load
// - EX_Rd        in   REG_AW  destination register of instruction in EX
// - Branch       in   1       taken branch resolved in stage BRANCH_STAGE
// - Jump         in   1       j/jal/jr decoded in ID
// - Halt         in   1       halt opcode (6'b111111) decoded in ID
// - MemReq       in   1       MEM stage accessing data memory
// - MemReady     in   1       data memory completes this cycle
// - PCWre        out  1       PC write enable
// - IF_ID_Write  out  1       IF/ID register write enable
// - IF_ID_Flush  out  1       clear IF/ID
// - ID_EX_Flush  out  1       clear ID/EX (bubble)
// - EX_MEM_Flush out  1       clear EX/MEM
// - Stall_All    out  1       freeze all pipeline registers
// - MemTimeout   out  1       sticky; registered
// - State        out  2       current FSM state, for debug
// BEHAVIOUR
// - FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2, HALTED=3.
// - All outputs except MemTimeout are combinational from state and inputs.
// - Reset high (sampled at the edge): next state RUN, counters 0, MemTimeout 0.
//   While Reset is high: PCWre=0, IF_ID_Write=0, all three flushes=1, Stall_All=0.
// - Default in RUN: PCWre=1, IF_ID_Write=1, flushes=0, Stall_All=0.
// - Priority per cycle: MEM_WAIT condition > Branch > load-use > Jump > Halt.
// - Memory wait:
//   - MemReq && !MemReady in RUN or LU_STALL -> Stall_All=1, PCWre=0, IF_ID_Write=0, no flushes.
//   - Save the return state and enter MEM_WAIT; the wait counter increments each cycle in MEM_WAIT.
//   - Branch, Jump and Halt are ignored while stalled; upstream holds them stable.
//   - MemReady -> return to the saved state next cycle; the saved bubble count is preserved.
//   - Counter == MEM_WAIT_MAX -> MemTimeout=1 and go to HALTED.
// - Load-use condition: EX_MemRead && EX_Rd!=0 && (EX_Rd==ID_Rs || (ID_UsesRt && EX_Rd==ID_Rt)).
//   - Effect: PCWre=0, IF_ID_Write=0, ID_EX_Flush=1 this cycle.
//   - If LOAD_USE_BUBBLES>1: load bubble counter with LOAD_USE_BUBBLES-1 and enter LU_STALL.
//   - LU_STALL repeats the same outputs and decrements the counter; at 0, go to RUN.
// - Taken branch:
//   - IF_ID_Flush=1, ID_EX_Flush=1; EX_MEM_Flush=1 only if BRANCH_STAGE==3; PCWre=1 (redirect).
//   - Cancels a pending load-use or LU_STALL and suppresses Halt/Jump in the same cycle; next state RUN.
// - Jump (no branch, no load-use): IF_ID_Flush=1, PCWre=1, one cycle.
// - Halt (no higher-priority event): next state HALTED.
// - HALTED: PCWre=0, IF_ID_Write=0, IF_ID_Flush=1, other outputs 0. Exit only via Reset.
// - Load-use against r0 never stalls.
// - Reset asserted mid-stall or mid-wait aborts immediately with no residual bubble.
// STRUCTURE
// - pipeline_defs.vh holds state encodings, opcode constants (J=000010, JAL=000011, HALT=111111) and the stage IDs.
// - Sub-module hazard_detect (combinational): register comparator producing the load-use condition.
// - The rest (FSM, bubble counter, wait counter, output decode) lives in one always block plus an assign block.
// TESTING
// - Reset held 2 cycles -> PCWre=0 and all flushes=1 during reset; State=0, PCWre=1, MemTimeout=0 after release.
// - EX_MemRead=1, EX_Rd=8, ID_Rs=8, LOAD_USE_BUBBLES=2 -> PCWre=0 and ID_EX_Flush=1 for exactly 2 cycles, then RUN.
// - Same hazard with EX_Rd=0, or ID_UsesRt=0 with rt-only match -> no stall.
// - Branch=1 during LU_STALL, BRANCH_STAGE=3 -> IF_ID_/ID_EX_/EX_MEM_Flush=1, PCWre=1; State=RUN next cycle.
// - MemReq=1, MemReady=0 for 3 cycles -> Stall_All=1 for 3 cycles, resume; 16 cycles -> MemTimeout=1, State=3.
// - Halt=1 and Branch=1 together -> branch flush, no halt; Halt alone -> PCWre=0 held until Reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared FSM encoding and stage identifiers for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } ctrlStateT;

  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;

  // A branch resolved in MEM has one more wrong-path instruction, sitting in EX/MEM.
  function automatic logic branchFlushesExMem(input int branchStage);
    return (branchStage == STAGE_MEM);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module pipeline_hazard_ctrl_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRt,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRd,
  output logic              loadUse
);

  logic rsMatch;
  logic rtMatch;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rsMatch = (exRd == idRs);
  assign rtMatch = idUsesRt && (exRd == idRt);
  assign loadUse = exMemRead && (exRd != '0) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, branch/jump flushes,
// data-memory freeze with timeout, and a sticky halt.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW           = 5,
  parameter int BRANCH_STAGE     = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_WAIT_MAX     = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Halt,
  input  logic              MemReq,
  input  logic              MemReady,
  output logic              PCWre,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              EX_MEM_Flush,
  output logic              Stall_All,
  output logic              MemTimeout,
  output logic [1:0]        State
);

  localparam int WaitW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);
  localparam logic [1:0] BubLoad = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic BranchExMem = branchFlushesExMem(BRANCH_STAGE);

  ctrlStateT        stateReg, stateNext;
  ctrlStateT        savedReg, savedNext;
  ctrlStateT        effState;
  logic [1:0]       bubbleReg, bubbleNext;
  logic [WaitW-1:0] waitReg, waitNext;
  logic             timeoutReg, timeoutNext;
  logic             loadUse;
  logic             memBlocked;

  logic pcWre, ifIdWrite, ifIdFlush, idExFlush, exMemFlush, stallAll;

  pipeline_hazard_ctrl_hazard_detect #(
    .REG_AW(REG_AW)
  ) hazardDetect (
    .idRs     (ID_Rs),
    .idRt     (ID_Rt),
    .idUsesRt (ID_UsesRt),
    .exMemRead(EX_MemRead),
    .exRd     (EX_Rd),
    .loadUse  (loadUse)
  );

  assign memBlocked = MemReq && !MemReady;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stateReg   <= RUN;
      savedReg   <= RUN;
      bubbleReg  <= '0;
      waitReg    <= '0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      savedReg   <= savedNext;
      bubbleReg  <= bubbleNext;
      waitReg    <= waitNext;
      timeoutReg <= timeoutNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    savedNext   = savedReg;
    bubbleNext  = bubbleReg;
    waitNext    = waitReg;
    timeoutNext = timeoutReg;
    pcWre       = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    exMemFlush  = 1'b0;
    stallAll    = 1'b0;

    // The cycle memory completes is an ordinary cycle of the interrupted state.
    effState = (stateReg == MEM_WAIT && MemReady) ? savedReg : stateReg;

    case (effState)
      HALTED: begin
        pcWre     = 1'b0;
        ifIdWrite = 1'b0;
        ifIdFlush = 1'b1;
      end
      MEM_WAIT: begin
        stallAll  = 1'b1;
        pcWre     = 1'b0;
        ifIdWrite = 1'b0;
        if (waitReg == WaitLast) begin
          timeoutNext = 1'b1;
          stateNext   = HALTED;
        end else begin
          waitNext = waitReg + 1'b1;
        end
      end
      default: begin
        stateNext = effState;
        if (memBlocked) begin
          stallAll  = 1'b1;
          pcWre     = 1'b0;
          ifIdWrite = 1'b0;
          savedNext = effState;
          waitNext  = '0;
          stateNext = MEM_WAIT;
        end else if (Branch) begin
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
          exMemFlush = BranchExMem;
          bubbleNext = '0;
          stateNext  = RUN;
        end else if (effState == LU_STALL || loadUse) begin
          pcWre     = 1'b0;
          ifIdWrite = 1'b0;
          idExFlush = 1'b1;
          if (effState == LU_STALL) begin
            if (bubbleReg <= 2'd1) begin
              bubbleNext = '0;
              stateNext  = RUN;
            end else begin
              bubbleNext = bubbleReg - 1'b1;
            end
          end else if (LOAD_USE_BUBBLES > 1) begin
            bubbleNext = BubLoad;
            stateNext  = LU_STALL;
          end
        end else if (Jump) begin
          ifIdFlush = 1'b1;
        end else if (Halt) begin
          stateNext = HALTED;
        end
      end
    endcase

    if (Reset) begin
      pcWre      = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
      stallAll   = 1'b0;
    end
  end

  assign PCWre        = pcWre;
  assign IF_ID_Write  = ifIdWrite;
  assign IF_ID_Flush  = ifIdFlush;
  assign ID_EX_Flush  = idExFlush;
  assign EX_MEM_Flush = exMemFlush;
  assign Stall_All    = stallAll;
  assign MemTimeout   = timeoutReg;
  assign State        = stateReg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + short random bench for pipeline_hazard_ctrl, checked against a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int BSTAGE = 3;
  localparam int LUB    = 2;
  localparam int MWM    = 15;

  localparam int M_RUN = 0, M_LU = 1, M_WAIT = 2, M_HALT = 3;

  logic CLK = 1'b0;
  logic Reset;
  logic [REG_AW-1:0] ID_Rs, ID_Rt, EX_Rd;
  logic ID_UsesRt, EX_MemRead, Branch, Jump, Halt, MemReq, MemReady;
  logic PCWre, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Stall_All, MemTimeout;
  logic [1:0] State;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .BRANCH_STAGE(BSTAGE), .LOAD_USE_BUBBLES(LUB), .MEM_WAIT_MAX(MWM)
  ) dut (
    .CLK(CLK), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .Branch(Branch), .Jump(Jump), .Halt(Halt),
    .MemReq(MemReq), .MemReady(MemReady), .PCWre(PCWre), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .Stall_All(Stall_All), .MemTimeout(MemTimeout), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: mode, remaining owed bubbles, not-ready cycles seen in the current wait.
  int  mMode = M_RUN, mSaved = M_RUN, mOwed = 0, mWaits = 0;
  bit  mTimeout = 1'b0;
  int  nMode = M_RUN, nSaved = M_RUN, nOwed = 0, nWaits = 0;
  bit  nTimeout = 1'b0;
  bit  modelOn = 1'b0;

  always @(negedge CLK) begin
    int eP, eW, eIf, eIe, eEm, eSa, m, tMode, tSaved, tOwed, tWaits;
    bit tTo, lu;
    eP = 1; eW = 1; eIf = 0; eIe = 0; eEm = 0; eSa = 0;
    tMode = mMode; tSaved = mSaved; tOwed = mOwed; tWaits = mWaits; tTo = mTimeout;
    lu = EX_MemRead && (EX_Rd != 0) && ((EX_Rd == ID_Rs) || (ID_UsesRt && EX_Rd == ID_Rt));
    if (mMode == M_HALT) begin
      eP = 0; eW = 0; eIf = 1;
    end else if (mMode == M_WAIT && !MemReady) begin
      eSa = 1; eP = 0; eW = 0;
      tWaits = mWaits + 1;
      if (tWaits > MWM) begin tTo = 1; tMode = M_HALT; end
    end else begin
      m = (mMode == M_WAIT) ? mSaved : mMode;
      tMode = m;
      if (MemReq && !MemReady) begin
        eSa = 1; eP = 0; eW = 0; tSaved = m; tWaits = 1; tMode = M_WAIT;
      end else if (Branch) begin
        eIf = 1; eIe = 1; eEm = (BSTAGE == 3) ? 1 : 0; tMode = M_RUN; tOwed = 0;
      end else if (m == M_LU || lu) begin
        eP = 0; eW = 0; eIe = 1;
        tOwed = (m == M_LU) ? mOwed - 1 : LUB - 1;
        tMode = (tOwed > 0) ? M_LU : M_RUN;
      end else if (Jump) begin
        eIf = 1;
      end else if (Halt) begin
        tMode = M_HALT;
      end
    end
    if (Reset) begin
      eP = 0; eW = 0; eIf = 1; eIe = 1; eEm = 1; eSa = 0;
      tMode = M_RUN; tSaved = M_RUN; tOwed = 0; tWaits = 0; tTo = 0;
    end
    if (modelOn) begin
      chk("m_PCWre", PCWre, eP);
      chk("m_IF_ID_Write", IF_ID_Write, eW);
      chk("m_IF_ID_Flush", IF_ID_Flush, eIf);
      chk("m_ID_EX_Flush", ID_EX_Flush, eIe);
      chk("m_EX_MEM_Flush", EX_MEM_Flush, eEm);
      chk("m_Stall_All", Stall_All, eSa);
      chk("m_State", State, mMode);
      chk("m_MemTimeout", MemTimeout, mTimeout);
    end
    nMode <= tMode; nSaved <= tSaved; nOwed <= tOwed; nWaits <= tWaits; nTimeout <= tTo;
  end

  always @(posedge CLK) begin
    if (Reset) modelOn <= 1'b1;
    mMode <= nMode; mSaved <= nSaved; mOwed <= nOwed; mWaits <= nWaits; mTimeout <= nTimeout;
  end

  task automatic clr();
    Reset = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_Rd = 0;
    Branch = 0; Jump = 0; Halt = 0; MemReq = 0; MemReady = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic hazard(input int rd, input int rs, input int rt, input bit usesRt);
    EX_MemRead = 1; EX_Rd = REG_AW'(rd); ID_Rs = REG_AW'(rs); ID_Rt = REG_AW'(rt); ID_UsesRt = usesRt;
  endtask

  initial begin
    clr(); Reset = 1;
    $display("txn reset hold");
    tick(); #1;
    chk("rst_PCWre", PCWre, 0); chk("rst_IF_ID_Flush", IF_ID_Flush, 1);
    chk("rst_ID_EX_Flush", ID_EX_Flush, 1); chk("rst_EX_MEM_Flush", EX_MEM_Flush, 1);
    tick(); Reset = 0; #1;
    $display("txn reset release");
    chk("rel_State", State, 0); chk("rel_PCWre", PCWre, 1); chk("rel_MemTimeout", MemTimeout, 0);

    $display("txn load-use rs match r8");
    hazard(8, 8, 0, 0); #1;
    chk("lu1_PCWre", PCWre, 0); chk("lu1_ID_EX_Flush", ID_EX_Flush, 1);
    tick(); #1;
    chk("lu2_State", State, 1); chk("lu2_PCWre", PCWre, 0); chk("lu2_ID_EX_Flush", ID_EX_Flush, 1);
    tick(); clr(); #1;
    chk("lu3_State", State, 0); chk("lu3_PCWre", PCWre, 1); chk("lu3_ID_EX_Flush", ID_EX_Flush, 0);

    $display("txn load-use r0 and rt-unused");
    hazard(0, 0, 0, 1); #1; chk("r0_PCWre", PCWre, 1);
    tick(); hazard(9, 3, 9, 0); #1; chk("rtoff_PCWre", PCWre, 1);
    tick(); hazard(9, 3, 9, 1); #1; chk("rton_PCWre", PCWre, 0);
    tick(); clr(); tick();

    $display("txn branch during LU_STALL");
    hazard(5, 5, 0, 0); tick(); Branch = 1; #1;
    chk("br_State", State, 1); chk("br_IF_ID_Flush", IF_ID_Flush, 1);
    chk("br_ID_EX_Flush", ID_EX_Flush, 1); chk("br_EX_MEM_Flush", EX_MEM_Flush, 1); chk("br_PCWre", PCWre, 1);
    tick(); clr(); #1; chk("br_next_State", State, 0);

    $display("txn memory wait 3 cycles");
    MemReq = 1; MemReady = 0;
    for (int i = 0; i < 3; i++) begin #1; chk("mw_Stall_All", Stall_All, 1); tick(); end
    MemReady = 1; #1; chk("mw_rel_Stall_All", Stall_All, 0); chk("mw_rel_PCWre", PCWre, 1);
    tick(); clr(); #1; chk("mw_State", State, 0);

    $display("txn jump");
    Jump = 1; #1; chk("j_IF_ID_Flush", IF_ID_Flush, 1); chk("j_PCWre", PCWre, 1); chk("j_ID_EX_Flush", ID_EX_Flush, 0);
    tick(); clr();

    $display("txn halt with branch");
    Halt = 1; Branch = 1; #1; chk("hb_IF_ID_Flush", IF_ID_Flush, 1); chk("hb_PCWre", PCWre, 1);
    tick(); clr(); #1; chk("hb_State", State, 0);

    $display("txn memory wait inside LU_STALL");
    hazard(7, 0, 7, 1); tick(); clr(); MemReq = 1; #1; chk("lm_Stall_All", Stall_All, 1);
    tick(); #1; chk("lm_State", State, 2);
    tick(); MemReady = 1; #1; chk("lm_rel_ID_EX_Flush", ID_EX_Flush, 1); chk("lm_rel_PCWre", PCWre, 0);
    tick(); clr(); #1; chk("lm_State_end", State, 0);

    $display("txn memory timeout");
    MemReq = 1; MemReady = 0;
    repeat (15) tick();
    #1; chk("to15_State", State, 2); chk("to15_MemTimeout", MemTimeout, 0);
    tick(); #1; chk("to16_State", State, 3); chk("to16_MemTimeout", MemTimeout, 1);
    clr(); Jump = 1;
    repeat (3) begin #1; chk("hlt_PCWre", PCWre, 0); chk("hlt_IF_ID_Flush", IF_ID_Flush, 1); tick(); end
    clr(); Reset = 1; tick(); Reset = 0; #1;
    chk("rst2_State", State, 0); chk("rst2_MemTimeout", MemTimeout, 0);

    $display("txn halt alone");
    Halt = 1; #1; chk("h_PCWre", PCWre, 1);
    tick(); clr();
    repeat (4) begin #1; chk("h_hold_PCWre", PCWre, 0); chk("h_hold_State", State, 3); tick(); end
    Reset = 1; tick(); clr();

    $display("txn reset during LU_STALL");
    hazard(4, 4, 0, 0); tick(); Reset = 1; #1; chk("rlu_PCWre", PCWre, 0);
    tick(); clr(); #1; chk("rlu_State", State, 0); chk("rlu_PCWre", PCWre, 1);

    $display("txn random phase");
    for (int c = 0; c < 400; c++) begin
      Reset      = ($urandom_range(0, 59) == 0);
      ID_Rs      = REG_AW'($urandom_range(0, 3));
      ID_Rt      = REG_AW'($urandom_range(0, 3));
      EX_Rd      = REG_AW'($urandom_range(0, 3));
      ID_UsesRt  = $urandom_range(0, 1) == 1;
      EX_MemRead = $urandom_range(0, 2) == 0;
      Branch     = $urandom_range(0, 5) == 0;
      Jump       = $urandom_range(0, 5) == 0;
      Halt       = $urandom_range(0, 39) == 0;
      MemReq     = $urandom_range(0, 3) == 0;
      MemReady   = $urandom_range(0, 1) == 1;
      tick();
    end
    clr(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
